// File: rtl/frame_fetch_if.sv
// frame_fetch_if: bundles the video fetch stage's control, memory and pixel
// signals.
//   image_select, frame_start : frame control from the VGA timing side
//   pixel_req / pixel / pixel_valid : one-pixel-per-request pop handshake
//   mem_addr / mem_rdata : read-only video port of data memory
//   ready, underflow : fetch status back to the VGA side
// Modports:
//   master : the fetch stage
//   slave  : its environment (VGA stage plus memory)
interface frame_fetch_if;
  logic        image_select;
  logic        frame_start;
  logic        pixel_req;
  logic [7:0]  mem_rdata;
  logic [31:0] mem_addr;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        ready;
  logic        underflow;

  modport master (
    input  image_select, frame_start, pixel_req, mem_rdata,
    output mem_addr, pixel, pixel_valid, ready, underflow
  );

  modport slave (
    output image_select, frame_start, pixel_req, mem_rdata,
    input  mem_addr, pixel, pixel_valid, ready, underflow
  );
endinterface

// File: rtl/frame_fetch.sv
// frame_fetch: streams 8-bit pixels of one of two images out of data memory
// into a small prefetch FIFO and hands one pixel per request to the VGA stage.
// The fixed memory read latency is absorbed by a valid shift register that
// tracks reads in flight.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : frame_fetch_if.master
//           (frame control, pixel handshake, video memory port, status)
module frame_fetch #(
  parameter int          IMG_W       = 256,
  parameter int          IMG_H       = 256,
  parameter logic [31:0] BASE0       = 32'd0,
  parameter logic [31:0] BASE1       = 32'd65536,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  frame_fetch_if.master bus
);

  localparam logic [31:0] TOTAL = 32'(IMG_W * IMG_H);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam int          CW    = AW + 1;
  localparam int          OW    = CW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_r;
  logic [31:0]            mem_addr_r;
  logic [31:0]            fetch_cnt_r;
  logic [MEM_LATENCY-1:0] inflight_sr_r;
  logic [7:0]             fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr_r;
  logic [AW-1:0]          wr_ptr_r;
  logic [CW-1:0]          fifo_cnt_r;
  logic [7:0]             pixel_r;
  logic                   pixel_valid_r;
  logic                   ready_r;
  logic                   underflow_r;

  logic [1:0]             inflight_cnt_s;
  logic [OW-1:0]          occ_s;
  logic                   issue_s;
  logic                   push_s;
  logic                   pop_s;
  logic [MEM_LATENCY-1:0] inflight_next_s;
  logic [CW-1:0]          fifo_cnt_next_s;
  logic [31:0]            fetch_cnt_next_s;

  assign bus.mem_addr    = mem_addr_r;
  assign bus.pixel       = pixel_r;
  assign bus.pixel_valid = pixel_valid_r;
  assign bus.ready       = ready_r;
  assign bus.underflow   = underflow_r;

  // Issue/push/pop decisions from registered counts only; a pop in the same
  // cycle never frees room for an issue.
  always_comb begin
    inflight_cnt_s = 2'd0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight_cnt_s = inflight_cnt_s + {1'b0, inflight_sr_r[i]};
    end
    occ_s = OW'(fifo_cnt_r) + OW'(inflight_cnt_s);

    if (!bus.frame_start && (state_r == FILL || state_r == RUN) &&
        (fetch_cnt_r < TOTAL) && (occ_s < OW'(FIFO_DEPTH))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end

    inflight_next_s    = '0;
    inflight_next_s[0] = issue_s;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      inflight_next_s[i] = inflight_sr_r[i-1];
    end

    push_s = inflight_sr_r[MEM_LATENCY-1];

    // No bypass: an empty FIFO cannot serve a pop even if data lands now.
    if (bus.pixel_req && !bus.frame_start && (fifo_cnt_r != CW'(0))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end

    fifo_cnt_next_s  = fifo_cnt_r + CW'(push_s) - CW'(pop_s);
    fetch_cnt_next_s = fetch_cnt_r + 32'(issue_s);
  end

  // Fetch FSM, address generator, prefetch FIFO and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      mem_addr_r    <= BASE0;
      fetch_cnt_r   <= 32'd0;
      inflight_sr_r <= '0;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      fifo_cnt_r    <= '0;
      pixel_r       <= 8'd0;
      pixel_valid_r <= 1'b0;
      ready_r       <= 1'b0;
      underflow_r   <= 1'b0;
    end else if (bus.frame_start) begin
      // Restart wins over everything, including a coincident pop; returning
      // data of the old frame is dropped by clearing the in-flight tracker.
      state_r       <= FILL;
      mem_addr_r    <= bus.image_select ? BASE1 : BASE0;
      fetch_cnt_r   <= 32'd0;
      inflight_sr_r <= '0;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      fifo_cnt_r    <= '0;
      pixel_r       <= 8'd0;
      pixel_valid_r <= 1'b0;
      ready_r       <= 1'b0;
      underflow_r   <= 1'b0;
    end else begin
      inflight_sr_r <= inflight_next_s;
      fifo_cnt_r    <= fifo_cnt_next_s;
      fetch_cnt_r   <= fetch_cnt_next_s;

      if (issue_s) begin
        mem_addr_r <= mem_addr_r + 32'd1;
      end

      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.mem_rdata;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end

      if (pop_s) begin
        pixel_r       <= fifo_mem_r[rd_ptr_r];
        pixel_valid_r <= 1'b1;
        rd_ptr_r      <= rd_ptr_r + AW'(1);
      end else if (bus.pixel_req) begin
        pixel_r       <= 8'd0;
        pixel_valid_r <= 1'b0;
        underflow_r   <= 1'b1;
      end else begin
        pixel_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: state_r <= IDLE;
        FILL: begin
          // Ready once the FIFO is full, or the whole (short) image is home.
          if ((fifo_cnt_next_s == CW'(FIFO_DEPTH)) ||
              ((fetch_cnt_next_s == TOTAL) && (inflight_next_s == '0))) begin
            state_r <= RUN;
            ready_r <= 1'b1;
          end
        end
        RUN: begin
          if ((fetch_cnt_r == TOTAL) && (inflight_sr_r == '0)) begin
            state_r <= DONE;
          end
        end
        DONE:    state_r <= DONE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fetch.sv
// tb_frame_fetch: directed self-checking bench for frame_fetch.
// Drives a full-size instance (256x256) and a 4x4 instance for the
// end-of-image case; each memory model returns addr[7:0] one cycle later.
module tb_frame_fetch;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_passed;
  int   n_valid;

  frame_fetch_if ifa ();
  frame_fetch_if ifb ();

  frame_fetch dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  frame_fetch #(.IMG_W(4), .IMG_H(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  // Clock generator.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models with one cycle read latency, data = low address byte.
  always @(posedge clk) begin
    ifa.mem_rdata <= ifa.mem_addr[7:0];
    ifb.mem_rdata <= ifb.mem_addr[7:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      n_passed++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a();
    for (int k = 0; k < 40; k++) begin
      if (ifa.ready) break;
      step();
    end
    check_eq("ready_wait_a", 32'(ifa.ready), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    reset = 1'b1;
    ifa.image_select = 1'b0; ifa.frame_start = 1'b0; ifa.pixel_req = 1'b0;
    ifb.image_select = 1'b0; ifb.frame_start = 1'b0; ifb.pixel_req = 1'b0;
    step();

    // Reset held two cycles with random inputs.
    for (int k = 0; k < 2; k++) begin
      ifa.image_select = 1'($urandom);
      ifa.frame_start  = 1'($urandom);
      ifa.pixel_req    = 1'($urandom);
      step();
    end
    reset = 1'b0;
    ifa.image_select = 1'b0; ifa.frame_start = 1'b0; ifa.pixel_req = 1'b0;
    check_eq("rst_mem_addr",  ifa.mem_addr, 32'd0);
    check_eq("rst_pixel",     32'(ifa.pixel), 32'd0);
    check_eq("rst_valid",     32'(ifa.pixel_valid), 32'd0);
    check_eq("rst_ready",     32'(ifa.ready), 32'd0);
    check_eq("rst_underflow", 32'(ifa.underflow), 32'd0);

    // Fill of image 1: frame_start in cycle 0, issues in cycles 1..8.
    ifa.image_select = 1'b1;
    ifa.frame_start  = 1'b1;
    step();
    ifa.frame_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check_eq($sformatf("fill_addr_c%0d", k), ifa.mem_addr, 32'd65536 + 32'(k - 1));
      step();
    end
    check_eq("fill_addr_c9",  ifa.mem_addr, 32'd65544);
    check_eq("fill_ready_c9", 32'(ifa.ready), 32'd0);
    step();
    check_eq("fill_ready_c10", 32'(ifa.ready), 32'd1);
    step();
    step();
    check_eq("fill_no_ninth", ifa.mem_addr, 32'd65544);

    // Stream 300 back-to-back pops.
    ifa.pixel_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 299) ifa.pixel_req = 1'b0;
      check_eq($sformatf("stream_valid_%0d", i), 32'(ifa.pixel_valid), 32'd1);
      check_eq($sformatf("stream_pixel_%0d", i), 32'(ifa.pixel), 32'(i % 256));
    end
    check_eq("stream_underflow", 32'(ifa.underflow), 32'd0);

    // Restart on image 0 coincident with a pop: restart wins.
    ifa.image_select = 1'b0;
    ifa.frame_start  = 1'b1;
    ifa.pixel_req    = 1'b1;
    step();
    ifa.frame_start = 1'b0;
    ifa.pixel_req   = 1'b0;
    check_eq("restart_addr",      ifa.mem_addr, 32'd0);
    check_eq("restart_valid",     32'(ifa.pixel_valid), 32'd0);
    check_eq("restart_underflow", 32'(ifa.underflow), 32'd0);
    check_eq("restart_ready",     32'(ifa.ready), 32'd0);
    wait_ready_a();
    ifa.pixel_req = 1'b1;
    step();
    ifa.pixel_req = 1'b0;
    check_eq("restart_pop0_valid", 32'(ifa.pixel_valid), 32'd1);
    check_eq("restart_pop0_pixel", 32'(ifa.pixel), 32'd0);
    step();
    check_eq("valid_pulse", 32'(ifa.pixel_valid), 32'd0);
    ifa.pixel_req = 1'b1;
    step();
    ifa.pixel_req = 1'b0;
    check_eq("restart_pop1_pixel", 32'(ifa.pixel), 32'd1);

    // Underflow: request in cycle 2 after frame_start.
    ifa.image_select = 1'b1;
    ifa.frame_start  = 1'b1;
    step();
    ifa.frame_start = 1'b0;
    step();
    ifa.pixel_req = 1'b1;
    step();
    ifa.pixel_req = 1'b0;
    check_eq("uf_valid", 32'(ifa.pixel_valid), 32'd0);
    check_eq("uf_pixel", 32'(ifa.pixel), 32'd0);
    check_eq("uf_flag",  32'(ifa.underflow), 32'd1);
    repeat (10) step();
    check_eq("uf_sticky", 32'(ifa.underflow), 32'd1);
    ifa.frame_start = 1'b1;
    step();
    ifa.frame_start = 1'b0;
    check_eq("uf_cleared", 32'(ifa.underflow), 32'd0);

    // Reset mid-frame.
    wait_ready_a();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_addr",  ifa.mem_addr, 32'd0);
    check_eq("midrst_ready", 32'(ifa.ready), 32'd0);
    check_eq("midrst_valid", 32'(ifa.pixel_valid), 32'd0);
    repeat (3) step();
    check_eq("midrst_idle_addr", ifa.mem_addr, 32'd0);

    // End of image on the 4x4 instance.
    ifb.image_select = 1'b0;
    ifb.frame_start  = 1'b1;
    step();
    ifb.frame_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ifb.ready) break;
      step();
    end
    check_eq("eoi_ready", 32'(ifb.ready), 32'd1);
    n_valid = 0;
    ifb.pixel_req = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 16) ifb.pixel_req = 1'b0;
      if (ifb.pixel_valid) begin
        check_eq($sformatf("eoi_pixel_%0d", n_valid), 32'(ifb.pixel), 32'(n_valid));
        n_valid++;
      end
      if (i == 15) check_eq("eoi_no_early_uf", 32'(ifb.underflow), 32'd0);
    end
    check_eq("eoi_count",     32'(n_valid), 32'd16);
    check_eq("eoi_underflow", 32'(ifb.underflow), 32'd1);
    check_eq("eoi_addr",      ifb.mem_addr, 32'd16);
    repeat (3) step();
    check_eq("eoi_addr_hold", ifb.mem_addr, 32'd16);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
